// File: rtl/riscv_pkg.sv
// Shared types for the core's memory-side blocks: requester ownership, arbiter
// states and the latched bus command.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic            we;
        logic [3:0]      be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one instruction/data memory bus between fetch (IF) and memory (DM) stages.
// Grant in the arbitration cycle, bus_req_o the cycle after, response routed with 0-cycle latency.
// One transaction outstanding; losers are held via gnt low and their stall output high.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    input  logic            if_kill_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,

    input  logic            dm_req_i,
    input  logic            dm_we_i,
    input  logic [3:0]      dm_be_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [XLEN-1:0] dm_rdata_o,

    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [3:0]      bus_be_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i,

    output logic            if_stall_o,
    output logic            dm_stall_o,
    output logic            busy_o
);

    localparam int unsigned     CW        = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   STARVE_LIM = CW'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    mem_cmd_t      cmd_q,   cmd_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          drop_q,  drop_d;

    logic arb_en;
    logic if_win;
    logic dm_win;
    logic resp_vld;
    logic drop_now;

    // Arbitration opens in IDLE and on the response cycle, so a waiting request
    // turns around onto the bus without an idle bubble.
    always_comb begin
        arb_en   = (state_q == ARB_IDLE) || ((state_q == ARB_WAIT) && bus_rvalid_i);
        if_win   = arb_en && if_req_i && !if_kill_i &&
                   (!dm_req_i || (starve_q == STARVE_LIM));
        dm_win   = arb_en && dm_req_i && !if_win;
        resp_vld = (state_q == ARB_WAIT) && bus_rvalid_i;
        drop_now = drop_q || (if_kill_i && (owner_q == OWN_IF));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_NONE;
            cmd_q    <= '0;
            starve_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cmd_q    <= cmd_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (if_win || dm_win) state_d = ARB_REQ;
            end
            ARB_REQ: begin
                if (bus_gnt_i) state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (bus_rvalid_i) state_d = (if_win || dm_win) ? ARB_REQ : ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        owner_d  = owner_q;
        cmd_d    = cmd_q;
        drop_d   = drop_q;
        starve_d = starve_q;

        if (arb_en) begin
            drop_d = 1'b0;
            if (if_win) begin
                owner_d     = OWN_IF;
                cmd_d.we    = 1'b0;
                cmd_d.be    = 4'hF;
                cmd_d.addr  = if_addr_i;
                cmd_d.wdata = '0;
            end else if (dm_win) begin
                owner_d     = OWN_DM;
                cmd_d.we    = dm_we_i;
                cmd_d.be    = dm_be_i;
                cmd_d.addr  = dm_addr_i;
                cmd_d.wdata = dm_wdata_i;
            end else begin
                owner_d     = OWN_NONE;
            end
        end else if (if_kill_i && (owner_q == OWN_IF)) begin
            drop_d = 1'b1;
        end

        // Only counts DM wins that actually kept a live IF request waiting.
        if (!if_req_i || if_win) begin
            starve_d = '0;
        end else if (dm_win && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_comb begin
        if_gnt_o    = if_win;
        dm_gnt_o    = dm_win;
        if_rvalid_o = resp_vld && (owner_q == OWN_IF) && !drop_now;
        dm_rvalid_o = resp_vld && (owner_q == OWN_DM);
        if_rdata_o  = if_rvalid_o ? bus_rdata_i : '0;
        dm_rdata_o  = dm_rvalid_o ? bus_rdata_i : '0;

        bus_req_o   = (state_q == ARB_REQ);
        bus_we_o    = cmd_q.we;
        bus_be_o    = cmd_q.be;
        bus_addr_o  = cmd_q.addr;
        bus_wdata_o = cmd_q.wdata;

        // A killed fetch no longer waits on its response.
        if_stall_o  = (if_req_i && !if_win) ||
                      ((owner_q == OWN_IF) && !if_rvalid_o && !drop_now);
        dm_stall_o  = (dm_req_i && !dm_win) ||
                      ((owner_q == OWN_DM) && !dm_rvalid_o);
        busy_o      = (state_q != ARB_IDLE);
    end

endmodule
